aes128_iter_core: RTL and testbench

AES128_ITER_CORE -- requirements
Module: aes128_iter_core

---
 rtl/aes128_pkg.sv | 52 +++++
 rtl/aes_sbox.sv | 31 +++
 rtl/aes128_iter_core.sv | 172 +++++++++++++++++
 tb/tb_aes128_iter_core.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes128_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers for the iterative core.
package aes128_pkg;

    localparam int unsigned NumRounds = 10;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;
    typedef logic [3:0]   round_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } fsm_e;

    localparam round_t LastRound = round_t'(NumRounds);

    // Round constants, indexed by round number 1..10.
    localparam logic [1:NumRounds][7:0] Rcon = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Rcon lookup that yields 0 outside the valid round range.
    function automatic byte_t rcon_of(round_t r);
        byte_t res;
        res = 8'h00;
        for (int unsigned i = 1; i <= NumRounds; i++) begin
            if (r == round_t'(i)) res = Rcon[i];
        end
        return res;
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic byte_t xtime(byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // MixColumns on one column; byte 0 (row 0) is the most significant byte.
    function automatic word_t mix_column(word_t col);
        byte_t a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: purely combinational 8-bit table lookup.
module aes_sbox
    import aes128_pkg::*;
(
    input  byte_t addr_i,
    output byte_t data_o
);

    // Entry 0 sits in the most significant byte.
    localparam logic [0:255][7:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign data_o = SboxTable[addr_i];

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor: one full round per clock, key schedule expanded on the fly.
module aes128_iter_core
    import aes128_pkg::*;
(
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [7:0]  key0,
    input  logic [7:0]  key1,
    input  logic [7:0]  key2,
    input  logic [7:0]  key3,
    input  logic [7:0]  key4,
    input  logic [7:0]  key5,
    input  logic [7:0]  key6,
    input  logic [7:0]  key7,
    input  logic [7:0]  key8,
    input  logic [7:0]  key9,
    input  logic [7:0]  key10,
    input  logic [7:0]  key11,
    input  logic [7:0]  key12,
    input  logic [7:0]  key13,
    input  logic [7:0]  key14,
    input  logic [7:0]  key15,
    input  logic [31:0] plaintext0,
    input  logic [31:0] plaintext1,
    input  logic [31:0] plaintext2,
    input  logic [31:0] plaintext3,
    input  logic        enable,
    input  logic        soft_reset,
    output logic [31:0] ciphertext0,
    output logic [31:0] ciphertext1,
    output logic [31:0] ciphertext2,
    output logic [31:0] ciphertext3,
    output logic        busy,
    output logic        done
);

    fsm_e   fsm_q, fsm_d;
    logic   enable_q;
    block_t blk_q, blk_d;
    block_t rk_q, rk_d;
    round_t round_q, round_d;
    block_t ct_q, ct_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    block_t key_in, pt_in;
    logic   start;
    block_t sub_blk, shifted, mixed, rk_next, round_out;
    word_t  key_sub, key_t;

    assign key_in = {key0, key1, key2, key3, key4, key5, key6, key7,
                     key8, key9, key10, key11, key12, key13, key14, key15};
    assign pt_in  = {plaintext0, plaintext1, plaintext2, plaintext3};
    assign start  = enable & ~enable_q;

    // Byte i of a block lives at bits [127-8i -: 8]; row = i % 4, column = i / 4.
    for (genvar g = 0; g < 16; g++) begin : g_state_sbox
        aes_sbox u_sbox (
            .addr_i (blk_q[127-8*g -: 8]),
            .data_o (sub_blk[127-8*g -: 8])
        );
    end

    // SubWord on the last round-key word; RotWord is applied afterwards as a byte rotation.
    for (genvar g = 0; g < 4; g++) begin : g_key_sbox
        aes_sbox u_sbox (
            .addr_i (rk_q[31-8*g -: 8]),
            .data_o (key_sub[31-8*g -: 8])
        );
    end

    // Round datapath: ShiftRows, MixColumns, next round key and AddRoundKey.
    always_comb begin
        shifted = '0;
        mixed   = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127-8*(r+4*c) -: 8] = sub_blk[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
        end

        key_t            = {key_sub[23:0], key_sub[31:24]} ^ {rcon_of(round_q), 24'h000000};
        rk_next[127:96]  = rk_q[127:96] ^ key_t;
        rk_next[95:64]   = rk_q[95:64]  ^ rk_next[127:96];
        rk_next[63:32]   = rk_q[63:32]  ^ rk_next[95:64];
        rk_next[31:0]    = rk_q[31:0]   ^ rk_next[63:32];

        // The final round skips MixColumns.
        round_out = ((round_q == LastRound) ? shifted : mixed) ^ rk_next;
    end

    // Control FSM next-state; soft_reset overrides any start in the same cycle.
    always_comb begin
        fsm_d   = fsm_q;
        blk_d   = blk_q;
        rk_d    = rk_q;
        round_d = round_q;
        ct_d    = ct_q;
        busy_d  = busy_q;
        done_d  = done_q;

        if (soft_reset) begin
            fsm_d   = StIdle;
            blk_d   = '0;
            rk_d    = '0;
            round_d = '0;
            ct_d    = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (fsm_q)
                StIdle, StDone: begin
                    if (start) begin
                        blk_d   = pt_in ^ key_in;
                        rk_d    = key_in;
                        round_d = 4'd1;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        fsm_d   = StRun;
                    end
                end
                StRun: begin
                    blk_d   = round_out;
                    rk_d    = rk_next;
                    round_d = round_q + 4'd1;
                    if (round_q == LastRound) begin
                        ct_d    = round_out;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        round_d = '0;
                        fsm_d   = StDone;
                    end
                end
                default: fsm_d = StIdle;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            fsm_q    <= StIdle;
            enable_q <= 1'b0;
            blk_q    <= '0;
            rk_q     <= '0;
            round_q  <= '0;
            ct_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            enable_q <= enable;
            blk_q    <= blk_d;
            rk_q     <= rk_d;
            round_q  <= round_d;
            ct_q     <= ct_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ciphertext0 = ct_q[127:96];
    assign ciphertext1 = ct_q[95:64];
    assign ciphertext2 = ct_q[63:32];
    assign ciphertext3 = ct_q[31:0];
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_aes128_iter_core.sv
// Self-checking bench for aes128_iter_core: FIPS-197 vectors, random blocks vs a reference model,
// input-change immunity, soft abort and asynchronous reset mid-run.
module tb_aes128_iter_core;

    localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         soft_reset;
    logic [127:0] key_v;
    logic [127:0] pt_v;
    wire  [31:0]  ct0, ct1, ct2, ct3;
    wire          busy, done;
    logic [127:0] ct_v;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sbox_tab [256];

    assign ct_v = {ct0, ct1, ct2, ct3};

    always #5 clk = ~clk;

    aes128_iter_core dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .key0          (key_v[127:120]),
        .key1          (key_v[119:112]),
        .key2          (key_v[111:104]),
        .key3          (key_v[103:96]),
        .key4          (key_v[95:88]),
        .key5          (key_v[87:80]),
        .key6          (key_v[79:72]),
        .key7          (key_v[71:64]),
        .key8          (key_v[63:56]),
        .key9          (key_v[55:48]),
        .key10         (key_v[47:40]),
        .key11         (key_v[39:32]),
        .key12         (key_v[31:24]),
        .key13         (key_v[23:16]),
        .key14         (key_v[15:8]),
        .key15         (key_v[7:0]),
        .plaintext0    (pt_v[127:96]),
        .plaintext1    (pt_v[95:64]),
        .plaintext2    (pt_v[63:32]),
        .plaintext3    (pt_v[31:0]),
        .enable        (enable),
        .soft_reset    (soft_reset),
        .ciphertext0   (ct0),
        .ciphertext1   (ct1),
        .ciphertext2   (ct2),
        .ciphertext3   (ct3),
        .busy          (busy),
        .done          (done)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // GF(2^8) multiply, shift-and-add with reduction by 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b};
        return d[15-k -: 8];
    endfunction

    // S-box derived from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, xb;
            xb  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                          ^ 8'h63;
        end
    endtask

    // Textbook AES-128: full key expansion up front, then ten rounds on a byte array.
    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]],
                       sbox_tab[tmp[31:24]]} ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    if (rnd < 10)
                        s[4*c+r] = gmul(8'h02, t[4*c+r]) ^ gmul(8'h03, t[4*c+(r+1)%4])
                                   ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
                    else
                        s[4*c+r] = t[4*c+r];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Fresh 0->1 on enable, then wait for done and check latency and result.
    task automatic run_vec(input string tag, input logic [127:0] k, input logic [127:0] p,
                           input logic [127:0] exp);
        int cyc;
        @(negedge clk);
        enable = 1'b0;
        key_v  = k;
        pt_v   = p;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check({tag, "_busy_after_capture"}, 128'(busy), 128'd1);
        check({tag, "_done_after_capture"}, 128'(done), 128'd0);
        cyc = 1;
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 128'(cyc - 1), 128'd10);
        check({tag, "_ct"}, ct_v, exp);
        check({tag, "_busy_at_done"}, 128'(busy), 128'd0);
    endtask

    initial begin
        int cyc;
        logic [127:0] k, p;
        build_sbox();
        rst_n      = 1'b0;
        enable     = 1'b0;
        soft_reset = 1'b0;
        key_v      = '0;
        pt_v       = '0;
        repeat (3) @(negedge clk);
        check("reset_ct", ct_v, 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 128'(busy), 128'd0);

        // Known-answer vectors, second one started straight from DONE.
        run_vec("fips_b", KeyB, PtB, CtB);
        run_vec("fips_c1", KeyC, PtC, CtC);

        for (int i = 0; i < 16; i++) begin
            k = rand128();
            p = rand128();
            run_vec($sformatf("rand%0d", i), k, p, aes_ref(k, p));
        end

        // Inputs change and enable toggles mid-run: result and timing must be unaffected.
        @(negedge clk);
        enable = 1'b0;
        key_v  = KeyB;
        pt_v   = PtB;
        @(negedge clk);
        enable = 1'b1;
        cyc = 0;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (cyc == 3) begin
                key_v = rand128();
                pt_v  = rand128();
            end
            if (cyc == 5) enable = 1'b0;
            if (cyc == 6) enable = 1'b1;
        end
        check("glitch_latency", 128'(cyc - 1), 128'd10);
        check("glitch_ct", ct_v, CtB);
        repeat (4) @(negedge clk);
        check("glitch_hold_done", 128'(done), 128'd1);
        check("glitch_hold_busy", 128'(busy), 128'd0);
        check("glitch_hold_ct", ct_v, CtB);

        // Soft abort at cycle 4 with enable held high.
        @(negedge clk);
        enable = 1'b0;
        key_v  = KeyB;
        pt_v   = PtB;
        @(negedge clk);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        check("soft_busy_before", 128'(busy), 128'd1);
        soft_reset = 1'b1;
        @(negedge clk);
        soft_reset = 1'b0;
        check("soft_ct", ct_v, 128'd0);
        check("soft_busy", 128'(busy), 128'd0);
        check("soft_done", 128'(done), 128'd0);
        repeat (5) @(negedge clk);
        check("soft_no_retrigger_busy", 128'(busy), 128'd0);
        check("soft_no_retrigger_done", 128'(done), 128'd0);
        run_vec("soft_then_c1", KeyC, PtC, CtC);

        // Asynchronous reset pulse mid-run.
        k = rand128();
        p = rand128();
        @(negedge clk);
        enable = 1'b0;
        key_v  = k;
        pt_v   = p;
        @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ct", ct_v, 128'd0);
        check("arst_busy", 128'(busy), 128'd0);
        check("arst_done", 128'(done), 128'd0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_idle_busy", 128'(busy), 128'd0);
        k = rand128();
        p = rand128();
        run_vec("arst_then_rand", k, p, aes_ref(k, p));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
